// File: rtl/mux_n_registrado_pkg.sv
// Shared definitions for the registered N:1 selector: buffer states and
// selector-width helper.
package mux_n_registrado_pkg;

  // Encoding 2'd3 is unused and recovers to EMPTY.
  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } buf_state_t;

  // Bits needed to index n channels, never less than one.
  function automatic int sel_width(input int n);
    int w;
    w = 1;
    while ((1 << w) < n) w = w + 1;
    return w;
  endfunction

endpackage

// File: rtl/mux_n_registrado_skid_buffer.sv
// Two-entry valid/ready buffer (main + skid) with registered o_valid/o_ready,
// one-cycle latency and synchronous flush.
module mux_skid_buffer
  import mux_n_registrado_pkg::*;
#(
  parameter int DATA_LENGTH = 12
) (
  input  logic                   i_clock,
  input  logic                   i_reset,
  input  logic                   i_flush,
  input  logic [DATA_LENGTH-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic [DATA_LENGTH-1:0] o_data,
  output logic                   o_valid,
  input  logic                   i_ready
);

  buf_state_t             state;
  buf_state_t             state_next;
  logic [DATA_LENGTH-1:0] main_q;
  logic [DATA_LENGTH-1:0] skid_q;
  logic                   valid_q;
  logic                   ready_q;
  logic                   accept;
  logic                   consume;
  logic                   load_main_in;
  logic                   load_skid_in;
  logic                   load_main_skid;
  logic                   clear_main;

  assign accept  = i_valid & ready_q;
  assign consume = valid_q & i_ready;

  always_comb begin
    state_next     = state;
    load_main_in   = 1'b0;
    load_skid_in   = 1'b0;
    load_main_skid = 1'b0;
    clear_main     = 1'b0;
    if (i_flush) begin
      state_next = EMPTY;
      clear_main = 1'b1;
    end else begin
      case (state)
        EMPTY: begin
          if (accept) begin
            load_main_in = 1'b1;
            state_next   = ONE;
          end
        end
        ONE: begin
          if (accept && consume) begin
            load_main_in = 1'b1;
          end else if (accept) begin
            load_skid_in = 1'b1;
            state_next   = FULL;
          end else if (consume) begin
            state_next = EMPTY;
          end
        end
        FULL: begin
          if (consume) begin
            load_main_skid = 1'b1;
            state_next     = ONE;
          end
        end
        default: state_next = EMPTY;
      endcase
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      state   <= EMPTY;
      valid_q <= 1'b0;
      ready_q <= 1'b1;
    end else begin
      state   <= state_next;
      // Handshake flags are registered from the next state so no input reaches them combinationally.
      valid_q <= (state_next != EMPTY);
      ready_q <= (state_next != FULL);
    end
  end

  always_ff @(posedge i_clock or posedge i_reset) begin
    if (i_reset) begin
      main_q <= '0;
      skid_q <= '0;
    end else begin
      if (clear_main)          main_q <= '0;
      else if (load_main_in)   main_q <= i_data;
      else if (load_main_skid) main_q <= skid_q;
      if (load_skid_in)        skid_q <= i_data;
    end
  end

  assign o_data  = main_q;
  assign o_valid = valid_q;
  assign o_ready = ready_q;

endmodule

// File: rtl/mux_n_registrado.sv
// N:1 channel selector with range check feeding a registered valid/ready
// output stage; the error bit travels alongside the data of each beat.
module mux_n_registrado
  import mux_n_registrado_pkg::*;
#(
  parameter  int INPUT_OUTPUT_LENGTH = 11,
  parameter  int NUM_INPUTS          = 4,
  localparam int SELECTOR_LENGTH     = sel_width(NUM_INPUTS)
) (
  input  logic                                      i_clock,
  input  logic                                      i_reset,
  input  logic [NUM_INPUTS*INPUT_OUTPUT_LENGTH-1:0] i_data,
  input  logic [SELECTOR_LENGTH-1:0]                i_selector,
  input  logic                                      i_valid,
  output logic                                      o_ready,
  input  logic                                      i_flush,
  output logic [INPUT_OUTPUT_LENGTH-1:0]            o_result,
  output logic                                      o_sel_error,
  output logic                                      o_valid,
  input  logic                                      i_ready
);

  localparam int DATA_LENGTH = INPUT_OUTPUT_LENGTH + 1;

  logic [INPUT_OUTPUT_LENGTH-1:0] sel_data;
  logic                           in_range;
  logic [DATA_LENGTH-1:0]         beat_in;
  logic [DATA_LENGTH-1:0]         beat_out;

  // An unmatched selector leaves data at zero and flags the beat.
  always_comb begin
    sel_data = '0;
    in_range = 1'b0;
    for (int unsigned k = 0; k < unsigned'(NUM_INPUTS); k++) begin
      if (i_selector == SELECTOR_LENGTH'(k)) begin
        sel_data = i_data[k*INPUT_OUTPUT_LENGTH +: INPUT_OUTPUT_LENGTH];
        in_range = 1'b1;
      end
    end
  end

  assign beat_in = {~in_range, sel_data};

  mux_skid_buffer #(
    .DATA_LENGTH(DATA_LENGTH)
  ) u_buffer (
    .i_clock (i_clock),
    .i_reset (i_reset),
    .i_flush (i_flush),
    .i_data  (beat_in),
    .i_valid (i_valid),
    .o_ready (o_ready),
    .o_data  (beat_out),
    .o_valid (o_valid),
    .i_ready (i_ready)
  );

  assign o_result    = beat_out[INPUT_OUTPUT_LENGTH-1:0];
  assign o_sel_error = beat_out[INPUT_OUTPUT_LENGTH];

endmodule

// File: tb/tb_mux_n_registrado.sv
// Bench for mux_n_registrado: vector table, corner sequences and a random run
// against a queue-based model of the two-beat buffer.
module tb_mux_n_registrado;

  logic        clk = 1'b0;
  logic        rst;

  logic [43:0] data4;
  logic [1:0]  sel4;
  logic        v4, rdy4, fl4, err4, ov4, dr4;
  logic [10:0] res4;

  logic [32:0] data3;
  logic [1:0]  sel3;
  logic        v3, rdy3, fl3, err3, ov3, dr3;
  logic [10:0] res3;

  int tests  = 0;
  int failed = 0;

  always #5 clk = ~clk;

  mux_n_registrado #(.INPUT_OUTPUT_LENGTH(11), .NUM_INPUTS(4)) dut4 (
    .i_clock(clk), .i_reset(rst), .i_data(data4), .i_selector(sel4),
    .i_valid(v4), .o_ready(rdy4), .i_flush(fl4), .o_result(res4),
    .o_sel_error(err4), .o_valid(ov4), .i_ready(dr4)
  );

  mux_n_registrado #(.INPUT_OUTPUT_LENGTH(11), .NUM_INPUTS(3)) dut3 (
    .i_clock(clk), .i_reset(rst), .i_data(data3), .i_selector(sel3),
    .i_valid(v3), .o_ready(rdy3), .i_flush(fl3), .o_result(res3),
    .o_sel_error(err3), .o_valid(ov3), .i_ready(dr3)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      failed++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  typedef struct {
    logic        v;
    logic [1:0]  sel;
    logic [10:0] d;
    logic        r;
    logic        f;
    logic        ev;
    logic        erdy;
    logic [10:0] eres;
  } vec_t;

  vec_t        tbl[14];
  logic [10:0] chans[4];
  logic [11:0] model_q[$];

  task automatic pack4();
    data4 = {chans[3], chans[2], chans[1], chans[0]};
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    // {valid, sel, data, i_ready, flush, exp_valid, exp_ready, exp_result}
    tbl[0]  = '{1'b1, 2'd0, 11'h001, 1'b1, 1'b0, 1'b1, 1'b1, 11'h001};
    tbl[1]  = '{1'b1, 2'd1, 11'h002, 1'b1, 1'b0, 1'b1, 1'b1, 11'h002};
    tbl[2]  = '{1'b1, 2'd2, 11'h004, 1'b1, 1'b0, 1'b1, 1'b1, 11'h004};
    tbl[3]  = '{1'b1, 2'd3, 11'h008, 1'b1, 1'b0, 1'b1, 1'b1, 11'h008};
    tbl[4]  = '{1'b0, 2'd0, 11'h000, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000};
    tbl[5]  = '{1'b1, 2'd1, 11'h123, 1'b0, 1'b0, 1'b1, 1'b1, 11'h123};
    tbl[6]  = '{1'b1, 2'd2, 11'h456, 1'b0, 1'b0, 1'b1, 1'b0, 11'h123};
    tbl[7]  = '{1'b1, 2'd0, 11'h777, 1'b0, 1'b0, 1'b1, 1'b0, 11'h123};
    tbl[8]  = '{1'b0, 2'd0, 11'h000, 1'b1, 1'b0, 1'b1, 1'b1, 11'h456};
    tbl[9]  = '{1'b0, 2'd0, 11'h000, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000};
    tbl[10] = '{1'b1, 2'd0, 11'h0AA, 1'b0, 1'b0, 1'b1, 1'b1, 11'h0AA};
    tbl[11] = '{1'b1, 2'd3, 11'h0BB, 1'b0, 1'b0, 1'b1, 1'b0, 11'h0AA};
    tbl[12] = '{1'b1, 2'd1, 11'h055, 1'b0, 1'b1, 1'b0, 1'b1, 11'h000};
    tbl[13] = '{1'b0, 2'd0, 11'h000, 1'b1, 1'b0, 1'b0, 1'b1, 11'h000};

    // Reset held three cycles while beats are offered.
    rst = 1'b1;
    for (int i = 0; i < 4; i++) chans[i] = 11'h3AA;
    pack4();
    sel4 = 2'd0; v4 = 1'b1; fl4 = 1'b0; dr4 = 1'b1;
    data3 = '1; sel3 = 2'd0; v3 = 1'b1; fl3 = 1'b0; dr3 = 1'b1;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      chk("reset_valid", 32'(ov4), 32'd0);
      chk("reset_result", 32'(res4), 32'd0);
      chk("reset_err", 32'(err4), 32'd0);
      chk("reset_ready", 32'(rdy4), 32'd1);
    end
    rst = 1'b0; v4 = 1'b0; v3 = 1'b0;

    for (int i = 0; i < 14; i++) begin
      for (int k = 0; k < 4; k++) chans[k] = 11'h3AA;
      chans[tbl[i].sel] = tbl[i].d;
      pack4();
      sel4 = tbl[i].sel; v4 = tbl[i].v; dr4 = tbl[i].r; fl4 = tbl[i].f;
      @(posedge clk); #1;
      chk($sformatf("tbl%0d_valid", i), 32'(ov4), 32'(tbl[i].ev));
      chk($sformatf("tbl%0d_ready", i), 32'(rdy4), 32'(tbl[i].erdy));
      if (tbl[i].ev) begin
        chk($sformatf("tbl%0d_result", i), 32'(res4), 32'(tbl[i].eres));
        chk($sformatf("tbl%0d_err", i), 32'(err4), 32'd0);
      end
    end
    fl4 = 1'b0; v4 = 1'b0; dr4 = 1'b1;

    // Three-channel instance: selector 3 is out of range.
    data3 = '1; sel3 = 2'd3; v3 = 1'b1;
    @(posedge clk); #1;
    chk("oor_valid", 32'(ov3), 32'd1);
    chk("oor_result", 32'(res3), 32'h000);
    chk("oor_err", 32'(err3), 32'd1);
    sel3 = 2'd2;
    @(posedge clk); #1;
    chk("inrange_result", 32'(res3), 32'h7FF);
    chk("inrange_err_not_sticky", 32'(err3), 32'd0);
    v3 = 1'b0;
    @(posedge clk); #1;
    chk("oor_drain_valid", 32'(ov3), 32'd0);

    // Random traffic against a queue model; buffer capacity is two beats.
    model_q.delete();
    for (int n = 0; n < 500; n++) begin
      for (int k = 0; k < 4; k++) chans[k] = 11'($urandom);
      pack4();
      sel4 = 2'($urandom_range(3, 0));
      v4   = 1'($urandom);
      dr4  = 1'($urandom);
      fl4  = ($urandom_range(15, 0) == 0);
      @(posedge clk);
      begin
        logic acc, con;
        acc = v4 && (model_q.size() < 2);
        con = (model_q.size() > 0) && dr4;
        if (fl4) model_q.delete();
        else begin
          if (con) void'(model_q.pop_front());
          if (acc) model_q.push_back({1'b0, chans[sel4]});
        end
      end
      #1;
      chk("rnd_valid", 32'(ov4), 32'(model_q.size() > 0));
      chk("rnd_ready", 32'(rdy4), 32'(model_q.size() < 2));
      if (model_q.size() > 0) begin
        chk("rnd_result", 32'(res4), 32'(model_q[0][10:0]));
        chk("rnd_err", 32'(err4), 32'd0);
      end
    end

    // Fill to FULL, then assert reset between edges.
    fl4 = 1'b1; v4 = 1'b0;
    @(posedge clk); #1;
    fl4 = 1'b0; v4 = 1'b1; dr4 = 1'b0;
    for (int k = 0; k < 4; k++) chans[k] = 11'h2C3;
    pack4();
    @(posedge clk); #1;
    @(posedge clk); #1;
    chk("pre_areset_ready", 32'(rdy4), 32'd0);
    chk("pre_areset_result", 32'(res4), 32'h2C3);
    #2 rst = 1'b1;
    #1;
    chk("areset_valid", 32'(ov4), 32'd0);
    chk("areset_ready", 32'(rdy4), 32'd1);
    chk("areset_result", 32'(res4), 32'd0);
    chk("areset_err", 32'(err4), 32'd0);
    #1 rst = 1'b0; v4 = 1'b0;
    @(posedge clk); #1;
    chk("post_areset_valid", 32'(ov4), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, failed);
    $finish;
  end

endmodule
